// File: rtl/sync_updown_counter_pkg.sv
// Shared constants for the synchronous up/down counter.
// Build option: define SYNC_UPDOWN_COUNTER_SATURATE_EN to saturate instead of wrap.
package sync_updown_counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int              DEF_WIDTH = 4;
  localparam longint unsigned DEF_MOD   = 16;

  // Uncomment (or pass on the command line) to hold at the end of range instead of rolling over.
  // `define SYNC_UPDOWN_COUNTER_SATURATE_EN

endpackage

// File: rtl/sync_updown_counter_mod_step.sv
// Combinational +1/-1 step modulo MOD, with rollover flag.
// Build option: SYNC_UPDOWN_COUNTER_SATURATE_EN selects saturation at the range ends.
module sync_updown_counter_mod_step
  import sync_updown_counter_pkg::*;
#(
  parameter int              WIDTH = DEF_WIDTH,
  parameter longint unsigned MOD   = DEF_MOD
) (
  input  logic [WIDTH-1:0] count,
  input  logic             up,
  output logic [WIDTH-1:0] next_count,
  output logic             rollover
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  logic [WIDTH:0] inc_w;
  logic [WIDTH:0] dec_w;
  logic           at_top;
  logic           at_bottom;

  // The extra bit makes MOD = 2**WIDTH compare correctly; the borrow bit flags 0 -> -1.
  assign inc_w     = {1'b0, count} + 1'b1;
  assign dec_w     = {1'b0, count} - 1'b1;
  assign at_top    = (inc_w == MOD_W);
  assign at_bottom = dec_w[WIDTH];

  always_comb begin
    next_count = count;
    rollover   = 1'b0;
    if (up == DIR_UP) begin
      if (at_top) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
        next_count = count;
`else
        next_count = '0;
        rollover   = 1'b1;
`endif
      end else begin
        next_count = inc_w[WIDTH-1:0];
      end
    end else begin
      if (at_bottom) begin
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
        next_count = count;
`else
        next_count = MAX_V;
        rollover   = 1'b1;
`endif
      end else begin
        next_count = dec_w[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/sync_updown_counter.sv
// Fully synchronous modulo-MOD up/down counter with load, terminal count and wrap pulse.
// Build option: SYNC_UPDOWN_COUNTER_SATURATE_EN holds at the range ends and keeps Wrap low.
module sync_updown_counter
  import sync_updown_counter_pkg::*;
#(
  parameter int              WIDTH     = DEF_WIDTH,
  parameter longint unsigned MOD       = DEF_MOD,
  parameter longint unsigned RESET_VAL = 0
) (
  input  logic             Clk,
  input  logic             Clr,
  input  logic             En,
  input  logic             Up,
  input  logic             Load,
  input  logic [WIDTH-1:0] LoadVal,
  output logic [WIDTH-1:0] count,
  output logic             Tc,
  output logic             Wrap,
  output logic             LoadErr
);

  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MOD - 1);

  // Stops elaboration on an illegal parameter set.
  if (WIDTH < 1 || WIDTH > 32 || MOD < 2 || MOD > (64'd1 << WIDTH) || RESET_VAL >= MOD) begin : g_param_chk
    $fatal(1, "sync_updown_counter: illegal WIDTH/MOD/RESET_VAL");
  end

  logic [WIDTH-1:0] step_val;
  logic             step_roll;
  logic             load_ok;

  sync_updown_counter_mod_step #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_step (
    .count      (count),
    .up         (Up),
    .next_count (step_val),
    .rollover   (step_roll)
  );

  assign load_ok = ({1'b0, LoadVal} < MOD_W);

  always_ff @(posedge Clk) begin
    if (Clr) begin
      count   <= WIDTH'(RESET_VAL);
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
    end else if (Load) begin
      if (load_ok) count <= LoadVal;
      Wrap    <= 1'b0;
      LoadErr <= ~load_ok;
    end else if (En) begin
      count   <= step_val;
`ifdef SYNC_UPDOWN_COUNTER_SATURATE_EN
      Wrap    <= 1'b0;
`else
      Wrap    <= step_roll;
`endif
      LoadErr <= 1'b0;
    end else begin
      Wrap    <= 1'b0;
      LoadErr <= 1'b0;
    end
  end

  // Left ungated by Load/Clr so a cascaded stage can use it as a same-cycle enable.
  assign Tc = En & (((Up == DIR_UP) & (count == MAX_V)) | ((Up == DIR_DOWN) & (count == '0)));

endmodule
